// File: rtl/sn_seq_pkg.sv
// Shared types and constants for the SN76489 write sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sn_seq_pkg;

  localparam int SN_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    WAIT  = 2'd3
  } sn_seq_state_t;

endpackage

// File: rtl/sn_write_sequencer_arbiter.sv
// Purpose: one-hot request arbiter (sn_rr_arbiter), round-robin from ptr+1,
//   or lowest-index fixed priority when SN_SEQ_FIXED_PRIORITY_EN is defined.
// Latency: combinational. Backpressure: none; gnt is all-zero when req is all-zero.
// Ports: req  - request vector
//        ptr  - index of the last winner (ignored in fixed-priority builds)
//        gnt  - one-hot winner
module sn_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef SN_SEQ_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan high to low so the lowest set index is the last to overwrite gnt.
  always_comb begin
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] idx;
  logic          found;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sn_write_sequencer.sv
// Purpose: arbitrate NUM_REQ command-byte requesters and serialise the winning
//   byte LSB-first into the SN76489 shift register, then strobe the latch.
// Latency: accept edge -> LATCH_STB 9 cycles; accept -> READY 1+8+1+WRITE_WAIT cycles.
// Backpressure: requests are only sampled in IDLE; REQ must be held until GNT.
// Ports: CLK/nRST (async active-low); REQ/REQ_DATA in; GNT one-hot pulse;
//   SR_DATA/SR_SHIFT drive the shift register; LATCH_STB/BYTE_OUT report the byte;
//   READY high only while idle.
// Build option: define SN_SEQ_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module sn_write_sequencer
  import sn_seq_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WRITE_WAIT = 32
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*SN_BYTE_W-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]             GNT,
  output logic                           SR_DATA,
  output logic                           SR_SHIFT,
  output logic                           LATCH_STB,
  output logic [SN_BYTE_W-1:0]           BYTE_OUT,
  output logic                           READY
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WCW = (WRITE_WAIT > 0) ? $clog2(WRITE_WAIT + 1) : 1;

  sn_seq_state_t          state_q, state_d;
  logic [2:0]             bit_cnt_q;
  logic [WCW-1:0]         wait_cnt_q;
  logic [SN_BYTE_W-1:0]   shadow_q;
  logic [SN_BYTE_W-1:0]   byte_q;
  logic [PW-1:0]          ptr_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     win;
  logic [SN_BYTE_W-1:0]   win_data;

  sn_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (win)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_data = REQ_DATA[SN_BYTE_W*i +: SN_BYTE_W];
    end
  end

`ifndef SN_SEQ_FIXED_PRIORITY_EN
  logic [PW-1:0] win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|REQ) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == 3'd7) state_d = LATCH;
      LATCH:   state_d = (WRITE_WAIT == 0) ? IDLE : WAIT;
      WAIT:    if (wait_cnt_q == WCW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shadow byte, counters, round-robin pointer, grant pulse
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      gnt_q      <= '0;
      shadow_q   <= '0;
      byte_q     <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      ptr_q      <= PW'(NUM_REQ - 1);
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (|REQ) begin
            shadow_q  <= win_data;
            gnt_q     <= win;
            bit_cnt_q <= '0;
`ifndef SN_SEQ_FIXED_PRIORITY_EN
            ptr_q     <= win_idx;
`endif
          end
        end
        SHIFT: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          // Publish the byte as the last bit goes out so BYTE_OUT is valid with LATCH_STB.
          if (bit_cnt_q == 3'd7) byte_q <= shadow_q;
        end
        LATCH:   wait_cnt_q <= WCW'(WRITE_WAIT);
        WAIT:    wait_cnt_q <= wait_cnt_q - WCW'(1);
        default: ;
      endcase
    end
  end

  assign GNT       = gnt_q;
  assign SR_SHIFT  = (state_q == SHIFT);
  assign SR_DATA   = SR_SHIFT & shadow_q[bit_cnt_q];
  assign LATCH_STB = (state_q == LATCH);
  assign BYTE_OUT  = byte_q;
  assign READY     = (state_q == IDLE);

endmodule
